// File: rtl/jk_input_conditioner.sv
// Input conditioner for a JK flip-flop: synchronises and debounces two raw push-buttons,
// then emits registered single-cycle J/K pulses on each accepted rising level.
module jk_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set_btn_i,
  input  logic       clr_btn_i,
  output logic       j_o,
  output logic       k_o,
  output logic       set_level_o,
  output logic       clr_level_o,
  output logic [7:0] glitch_cnt_o
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } deb_state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0] raw;
  logic [1:0] rise;
  logic [1:0] glitch;
  logic [1:0] level;

  assign raw = {clr_btn_i, set_btn_i};

  // Channel 0 is the set button, channel 1 the clear button.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   sync;
      deb_state_t             state_reg, state_next;
      logic [CNT_W-1:0]       cnt_reg, cnt_next;
      logic                   level_reg, level_next;
      logic                   rise_evt, glitch_evt;

      always_ff @(posedge clk) begin
        if (reset) begin
          sync_reg <= '0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw[gi]};
        end
      end

      assign sync = sync_reg[SYNC_STAGES-1];

      always_ff @(posedge clk) begin
        if (reset) begin
          state_reg <= STABLE_LO;
          cnt_reg   <= '0;
          level_reg <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          level_reg <= level_next;
        end
      end

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        level_next = level_reg;
        rise_evt   = 1'b0;
        glitch_evt = 1'b0;
        case (state_reg)
          STABLE_LO: begin
            if (sync) begin
              state_next = WAIT_HI;
              cnt_next   = CNT_ONE;
            end
          end
          WAIT_HI: begin
            if (sync) begin
              if (cnt_reg == CNT_LAST) begin
                state_next = STABLE_HI;
                cnt_next   = '0;
                level_next = 1'b1;
                rise_evt   = 1'b1;
              end else begin
                cnt_next = cnt_reg + CNT_ONE;
              end
            end else begin
              state_next = STABLE_LO;
              cnt_next   = '0;
              glitch_evt = 1'b1;
            end
          end
          STABLE_HI: begin
            if (!sync) begin
              state_next = WAIT_LO;
              cnt_next   = CNT_ONE;
            end
          end
          WAIT_LO: begin
            // A qualified release clears the level but never produces a pulse.
            if (!sync) begin
              if (cnt_reg == CNT_LAST) begin
                state_next = STABLE_LO;
                cnt_next   = '0;
                level_next = 1'b0;
              end else begin
                cnt_next = cnt_reg + CNT_ONE;
              end
            end else begin
              state_next = STABLE_HI;
              cnt_next   = '0;
              glitch_evt = 1'b1;
            end
          end
          default: begin
            state_next = STABLE_LO;
            cnt_next   = '0;
            level_next = 1'b0;
          end
        endcase
      end

      assign rise[gi]   = rise_evt;
      assign glitch[gi] = glitch_evt;
      assign level[gi]  = level_reg;
    end
  endgenerate

  logic       j_reg, k_reg;
  logic [7:0] glitch_cnt_reg, glitch_cnt_next;
  logic [8:0] glitch_sum;

  assign glitch_sum      = {1'b0, glitch_cnt_reg} + 9'(glitch[0]) + 9'(glitch[1]);
  assign glitch_cnt_next = glitch_sum[8] ? 8'hFF : glitch_sum[7:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      j_reg          <= 1'b0;
      k_reg          <= 1'b0;
      glitch_cnt_reg <= '0;
    end else begin
      j_reg          <= rise[0];
      k_reg          <= rise[1];
      glitch_cnt_reg <= glitch_cnt_next;
    end
  end

  // Masking with reset keeps a pulse already in the register from leaking out
  // during the cycle in which reset is first asserted.
  assign j_o          = j_reg & ~reset;
  assign k_o          = k_reg & ~reset;
  assign set_level_o  = level[0];
  assign clr_level_o  = level[1];
  assign glitch_cnt_o = glitch_cnt_reg;

endmodule

// File: tb/tb_jk_input_conditioner.sv
// Self-checking bench for jk_input_conditioner: directed scenarios plus randomized
// button activity compared against a run-length debounce model.
`timescale 1ns/1ps
module tb_jk_input_conditioner;

  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int CNT_W           = 3;
  localparam int LAT             = SYNC_STAGES + DEBOUNCE_CYCLES;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       set_btn_i = 1'b0;
  logic       clr_btn_i = 1'b0;
  logic       j_o, k_o, set_level_o, clr_level_o;
  logic [7:0] glitch_cnt_o;

  int checks = 0;
  int errors = 0;

  // Reference model state: delayed raw samples and run lengths of disagreement.
  bit sq_set[$];
  bit sq_clr[$];
  int run_set, run_clr, mglitch;
  bit ml_set, ml_clr, mj, mk;

  // Per-scenario tallies.
  int          j_cnt, k_cnt, both_cnt, mm_cnt;
  logic [11:0] mm_act, mm_exp;

  jk_input_conditioner #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .set_btn_i   (set_btn_i),
    .clr_btn_i   (clr_btn_i),
    .j_o         (j_o),
    .k_o         (k_o),
    .set_level_o (set_level_o),
    .clr_level_o (clr_level_o),
    .glitch_cnt_o(glitch_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic void chan_update(input bit s, inout int run, inout bit lvl,
                                      output bit rise, output bit glt);
    rise = 1'b0;
    glt  = 1'b0;
    if (s != lvl) begin
      run++;
      if (run == DEBOUNCE_CYCLES) begin
        lvl  = s;
        run  = 0;
        rise = s;
      end
    end else if (run > 0) begin
      glt = 1'b1;
      run = 0;
    end
  endfunction

  task automatic model_step();
    bit rs, rc, gs, gc;
    if (reset) begin
      sq_set.delete();
      sq_clr.delete();
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sq_set.push_back(1'b0);
        sq_clr.push_back(1'b0);
      end
      run_set = 0; run_clr = 0; ml_set = 0; ml_clr = 0;
      mj = 0; mk = 0; mglitch = 0;
    end else begin
      chan_update(sq_set[0], run_set, ml_set, rs, gs);
      chan_update(sq_clr[0], run_clr, ml_clr, rc, gc);
      void'(sq_set.pop_front());
      void'(sq_clr.pop_front());
      sq_set.push_back(set_btn_i);
      sq_clr.push_back(clr_btn_i);
      mglitch = mglitch + int'(gs) + int'(gc);
      if (mglitch > 255) mglitch = 255;
      mj = rs;
      mk = rc;
    end
  endtask

  // Advance one clock, update the model, then sample outputs on the falling edge.
  task automatic tick();
    logic [11:0] act, exp_v;
    @(posedge clk);
    model_step();
    @(negedge clk);
    act   = {j_o, k_o, set_level_o, clr_level_o, glitch_cnt_o};
    exp_v = {mj & ~reset, mk & ~reset, ml_set, ml_clr, 8'(mglitch)};
    if (j_o === 1'b1) j_cnt++;
    if (k_o === 1'b1) k_cnt++;
    if (j_o === 1'b1 && k_o === 1'b1) both_cnt++;
    if (act !== exp_v) begin
      if (mm_cnt == 0) begin
        mm_act = act;
        mm_exp = exp_v;
      end
      mm_cnt++;
    end
  endtask

  task automatic clear_tally();
    j_cnt = 0; k_cnt = 0; both_cnt = 0; mm_cnt = 0;
    mm_act = '0; mm_exp = '0;
  endtask

  task automatic do_reset();
    set_btn_i = 1'b0;
    clr_btn_i = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    clear_tally();
  endtask

  task automatic test_reset();
    logic [11:0] act;
    reset = 1'b1;
    set_btn_i = 1'b1;
    clr_btn_i = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    act = {j_o, k_o, set_level_o, clr_level_o, glitch_cnt_o};
    checks++;
    if (act !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", act, 12'h000);
    end
    $display("reset: outputs %h", act);
  endtask

  task automatic test_clean_press();
    int n;
    do_reset();
    set_btn_i = 1'b1;
    n = 0;
    do begin tick(); n++; end while (set_level_o !== 1'b1 && n < 50);
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (n !== LAT) begin errors++; $display("FAIL press_latency: got %0d expected %0d", n, LAT); end
    checks++;
    if (j_cnt !== 1) begin errors++; $display("FAIL press_j_pulses: got %0d expected 1", j_cnt); end
    checks++;
    if (k_cnt !== 0) begin errors++; $display("FAIL press_k_pulses: got %0d expected 0", k_cnt); end
    checks++;
    if (glitch_cnt_o !== 8'd0) begin errors++; $display("FAIL press_glitch: got %0d expected 0", glitch_cnt_o); end
    checks++;
    if (mm_cnt !== 0) begin errors++; $display("FAIL press_model: %0d cycles differ, first got %h expected %h", mm_cnt, mm_act, mm_exp); end
    $display("clean_press: latency %0d j %0d k %0d", n, j_cnt, k_cnt);
  endtask

  task automatic test_release();
    int n;
    clear_tally();
    set_btn_i = 1'b0;
    n = 0;
    do begin tick(); n++; end while (set_level_o !== 1'b0 && n < 50);
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (n !== LAT) begin errors++; $display("FAIL release_latency: got %0d expected %0d", n, LAT); end
    checks++;
    if (j_cnt !== 0 || k_cnt !== 0) begin errors++; $display("FAIL release_pulses: got j %0d k %0d expected 0 0", j_cnt, k_cnt); end
    checks++;
    if (mm_cnt !== 0) begin errors++; $display("FAIL release_model: %0d cycles differ, first got %h expected %h", mm_cnt, mm_act, mm_exp); end
    $display("release: latency %0d j %0d k %0d", n, j_cnt, k_cnt);
  endtask

  task automatic test_bounce();
    int n;
    do_reset();
    clr_btn_i = 1'b1;
    tick(); tick();
    clr_btn_i = 1'b0;
    tick(); tick(); tick();
    clr_btn_i = 1'b1;
    n = 0;
    do begin tick(); n++; end while (clr_level_o !== 1'b1 && n < 50);
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (glitch_cnt_o !== 8'd1) begin errors++; $display("FAIL bounce_glitch: got %0d expected 1", glitch_cnt_o); end
    checks++;
    if (n !== LAT) begin errors++; $display("FAIL bounce_latency: got %0d expected %0d", n, LAT); end
    checks++;
    if (k_cnt !== 1 || j_cnt !== 0) begin errors++; $display("FAIL bounce_pulses: got k %0d j %0d expected 1 0", k_cnt, j_cnt); end
    checks++;
    if (mm_cnt !== 0) begin errors++; $display("FAIL bounce_model: %0d cycles differ, first got %h expected %h", mm_cnt, mm_act, mm_exp); end
    $display("bounce: glitches %0d latency %0d k %0d", glitch_cnt_o, n, k_cnt);
  endtask

  task automatic test_simultaneous();
    int n;
    do_reset();
    set_btn_i = 1'b1;
    clr_btn_i = 1'b1;
    n = 0;
    do begin tick(); n++; end while ((set_level_o !== 1'b1 || clr_level_o !== 1'b1) && n < 50);
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (both_cnt !== 1) begin errors++; $display("FAIL simul_toggle: got %0d joint pulses expected 1", both_cnt); end
    checks++;
    if (j_cnt !== 1 || k_cnt !== 1) begin errors++; $display("FAIL simul_counts: got j %0d k %0d expected 1 1", j_cnt, k_cnt); end
    checks++;
    if (n !== LAT) begin errors++; $display("FAIL simul_latency: got %0d expected %0d", n, LAT); end
    checks++;
    if (mm_cnt !== 0) begin errors++; $display("FAIL simul_model: %0d cycles differ, first got %h expected %h", mm_cnt, mm_act, mm_exp); end
    $display("simultaneous: joint %0d j %0d k %0d", both_cnt, j_cnt, k_cnt);
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    set_btn_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (j_cnt !== 0) begin errors++; $display("FAIL midreset_suppress: got %0d pulses expected 0", j_cnt); end
    n = 0;
    do begin tick(); n++; end while (j_o !== 1'b1 && n < 50);
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (n !== LAT) begin errors++; $display("FAIL midreset_latency: got %0d expected %0d", n, LAT); end
    checks++;
    if (j_cnt !== 1) begin errors++; $display("FAIL midreset_pulses: got %0d expected 1", j_cnt); end
    checks++;
    if (mm_cnt !== 0) begin errors++; $display("FAIL midreset_model: %0d cycles differ, first got %h expected %h", mm_cnt, mm_act, mm_exp); end
    $display("reset_mid: latency %0d j %0d", n, j_cnt);
  endtask

  task automatic test_saturation();
    do_reset();
    for (int p = 0; p < 300; p++) begin
      set_btn_i = 1'b1;
      tick(); tick();
      set_btn_i = 1'b0;
      tick(); tick(); tick();
    end
    checks++;
    if (glitch_cnt_o !== 8'd255) begin errors++; $display("FAIL sat_value: got %0d expected 255", glitch_cnt_o); end
    set_btn_i = 1'b1;
    tick(); tick();
    set_btn_i = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (glitch_cnt_o !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d expected 255", glitch_cnt_o); end
    checks++;
    if (j_cnt !== 0) begin errors++; $display("FAIL sat_pulses: got %0d expected 0", j_cnt); end
    checks++;
    if (mm_cnt !== 0) begin errors++; $display("FAIL sat_model: %0d cycles differ, first got %h expected %h", mm_cnt, mm_act, mm_exp); end
    $display("saturation: glitches %0d j %0d", glitch_cnt_o, j_cnt);
  endtask

  task automatic test_random();
    int dur_set, dur_clr;
    do_reset();
    dur_set = 1;
    dur_clr = 1;
    for (int c = 0; c < 800; c++) begin
      dur_set--;
      dur_clr--;
      if (dur_set <= 0) begin
        set_btn_i = ~set_btn_i;
        dur_set = int'($urandom_range(1, 10));
      end
      if (dur_clr <= 0) begin
        clr_btn_i = ~clr_btn_i;
        dur_clr = int'($urandom_range(1, 10));
      end
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;
    tick();
    checks++;
    if (mm_cnt !== 0) begin errors++; $display("FAIL random_model: %0d cycles differ, first got %h expected %h", mm_cnt, mm_act, mm_exp); end
    $display("random: j %0d k %0d glitches %0d", j_cnt, k_cnt, glitch_cnt_o);
  endtask

  initial begin
    clear_tally();
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
